// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one synchronous-read instruction memory between the
// fetch unit and a loader port. Grants are combinational and responses
// return exactly one cycle after the grant. A loader lock keeps fetch off the
// memory while the loader needs exclusive access.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// UNLOCKED | normal round-robin arbitration between fetch and loader
// LOCKED   | loader holds the bus; fetch is refused while l_lock stays high
module imem_arbiter #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    output logic          f_err,
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    output logic          l_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [15:0]   stall_cnt
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t state_q, state_d;

    // 1 = loader wins the next contested cycle (fetch was granted last)
    logic        pri_l_q, pri_l_d;

    // one-deep response pipeline
    logic        rv_q, rv_d;
    logic        own_l_q, own_l_d;
    logic        rd_q, rd_d;
    logic        err_q, err_d;

    logic [15:0] stall_q, stall_d;

    logic        f_gnt_c, l_gnt_c, any_gnt, hold_lock, legal;
    logic [31:0] sel_addr;

    // word aligned and inside the 2**AW word window
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == 32'd0);
    endfunction

    // Lock FSM next state and grant decision; a lock only holds while l_lock
    // stays high, so the release cycle is already arbitrated normally.
    always_comb begin
        f_gnt_c   = 1'b0;
        l_gnt_c   = 1'b0;
        hold_lock = (state_q == LOCKED) && l_lock;
        if (!rst) begin
            if (hold_lock) begin
                l_gnt_c = l_req;
            end else if (f_req && l_req) begin
                if (pri_l_q) l_gnt_c = 1'b1;
                else         f_gnt_c = 1'b1;
            end else begin
                f_gnt_c = f_req;
                l_gnt_c = l_req;
            end
        end
        state_d = (hold_lock || (l_gnt_c && l_lock)) ? LOCKED : UNLOCKED;
    end

    // Memory access strobes, response bookkeeping and stall accounting
    always_comb begin
        any_gnt  = f_gnt_c | l_gnt_c;
        sel_addr = l_gnt_c ? l_addr : f_addr;
        legal    = addr_ok(sel_addr);

        mem_en    = any_gnt & legal;
        mem_we    = l_gnt_c & l_we & legal;
        mem_addr  = mem_en ? sel_addr[AW+1:2] : '0;
        mem_wdata = mem_en ? l_wdata : 32'd0;

        pri_l_d = f_gnt_c ? 1'b1 : (l_gnt_c ? 1'b0 : pri_l_q);

        rv_d    = any_gnt;
        own_l_d = l_gnt_c;
        rd_d    = any_gnt & legal & ~(l_gnt_c & l_we);
        err_d   = any_gnt & ~legal;

        stall_d = stall_q;
        if (f_req && !f_gnt_c && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // State registers; reset drops any pending response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UNLOCKED;
            pri_l_q <= 1'b0;
            rv_q    <= 1'b0;
            own_l_q <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            pri_l_q <= pri_l_d;
            rv_q    <= rv_d;
            own_l_q <= own_l_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    // Response routing; read data is passed straight from the memory port
    always_comb begin
        f_gnt     = f_gnt_c;
        l_gnt     = l_gnt_c;
        f_rvalid  = rv_q & ~own_l_q & ~rst;
        l_rvalid  = rv_q &  own_l_q & ~rst;
        f_err     = f_rvalid & err_q;
        l_err     = l_rvalid & err_q;
        f_rdata   = (f_rvalid && rd_q) ? mem_rdata : 32'd0;
        l_rdata   = (l_rvalid && rd_q) ? mem_rdata : 32'd0;
        stall_cnt = stall_q;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small synchronous memory model.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, l_req, l_we, l_lock;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err;
    logic [31:0] f_rdata, l_rdata, mem_wdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [15:0] stall_cnt;

    logic [31:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.AW(16)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid),
        .l_rdata(l_rdata), .l_err(l_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    // synchronous-read memory model
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'hA5A50008;
        mem_rdata = 32'h0BAD_0BAD;

        rst = 1'b1;
        f_req = 1'b1; l_req = 1'b1; l_we = 1'b1; l_lock = 1'b0;
        f_addr = 32'h10; l_addr = 32'h8; l_wdata = 32'hFFFF_FFFF;
        tick(); tick();
        #1;
        chk("rst_f_gnt", {31'd0, f_gnt}, 32'd0);
        chk("rst_l_gnt", {31'd0, l_gnt}, 32'd0);
        chk("rst_mem_en", {30'd0, mem_en, mem_we}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        chk("rst_resp", {28'd0, f_rvalid, l_rvalid, f_err, l_err}, 32'd0);
        chk("rst_rdata", f_rdata | l_rdata, 32'd0);

        // round robin from reset: F,L,F,L
        tick();
        rst = 1'b0; l_we = 1'b0; l_addr = 32'h20;
        #1;
        chk("rr1_f_gnt", {31'd0, f_gnt}, 32'd1);
        chk("rr1_l_gnt", {31'd0, l_gnt}, 32'd0);
        chk("rr1_mem", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'd4});
        tick(); #1;
        chk("rr2_gnt", {30'd0, f_gnt, l_gnt}, 32'd1);
        chk("rr2_mem_addr", {16'd0, mem_addr}, 32'd8);
        chk("rr2_f_rvalid", {30'd0, f_rvalid, f_err}, 32'd2);
        chk("rr2_f_rdata", f_rdata, 32'hDEADBEEF);
        tick(); #1;
        chk("rr3_gnt", {30'd0, f_gnt, l_gnt}, 32'd2);
        chk("rr3_l_rvalid", {31'd0, l_rvalid}, 32'd1);
        chk("rr3_l_rdata", l_rdata, 32'hA5A50008);
        chk("rr3_stall", {16'd0, stall_cnt}, 32'd1);
        tick(); #1;
        chk("rr4_gnt", {30'd0, f_gnt, l_gnt}, 32'd1);
        chk("rr4_f_rdata", f_rdata, 32'hDEADBEEF);
        tick();
        f_req = 1'b0; l_req = 1'b0;
        #1;
        chk("rr5_l_rvalid", {31'd0, l_rvalid}, 32'd1);
        chk("rr5_stall", {16'd0, stall_cnt}, 32'd2);
        chk("rr5_idle_gnt", {30'd0, f_gnt, l_gnt}, 32'd0);

        // loader write then fetch of the same word
        tick();
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h8; l_wdata = 32'h12345678;
        #1;
        chk("wr_l_gnt", {31'd0, l_gnt}, 32'd1);
        chk("wr_mem_we", {30'd0, mem_en, mem_we}, 32'd3);
        chk("wr_mem_addr", {16'd0, mem_addr}, 32'd2);
        chk("wr_mem_wdata", mem_wdata, 32'h12345678);
        tick();
        l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h8;
        #1;
        chk("wr_ack", {30'd0, l_rvalid, l_err}, 32'd2);
        chk("wr_ack_rdata", l_rdata, 32'd0);
        chk("rd_f_gnt", {31'd0, f_gnt}, 32'd1);
        chk("rd_mem_we", {31'd0, mem_we}, 32'd0);

        // illegal fetch addresses: misaligned and out of window
        tick();
        f_addr = 32'h6;
        #1;
        chk("rd_f_rdata", f_rdata, 32'h12345678);
        chk("mis_gnt", {31'd0, f_gnt}, 32'd1);
        chk("mis_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        f_addr = 32'h0004_0000;
        #1;
        chk("mis_resp", {30'd0, f_rvalid, f_err}, 32'd3);
        chk("mis_rdata", f_rdata, 32'd0);
        chk("oor_gnt", {30'd0, f_gnt, mem_en}, 32'd2);
        tick();
        f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h2;
        #1;
        chk("oor_resp", {30'd0, f_rvalid, f_err}, 32'd3);
        chk("oor_rdata", f_rdata, 32'd0);
        chk("lmis_gnt", {29'd0, l_gnt, mem_en, mem_we}, 32'd4);
        tick();
        l_req = 1'b0; l_we = 1'b0;
        #1;
        chk("lmis_resp", {30'd0, l_rvalid, l_err}, 32'd3);

        // lock: loader takes the bus, fetch refused until l_lock drops
        tick();
        l_req = 1'b1; l_lock = 1'b1; l_addr = 32'h20;
        #1;
        chk("lk1_l_gnt", {31'd0, l_gnt}, 32'd1);
        tick();
        f_req = 1'b1; f_addr = 32'h10;
        #1;
        chk("lk2_gnt", {30'd0, f_gnt, l_gnt}, 32'd1);
        tick(); #1;
        chk("lk3_gnt", {30'd0, f_gnt, l_gnt}, 32'd1);
        tick();
        l_lock = 1'b0;
        #1;
        chk("unlk_gnt", {30'd0, f_gnt, l_gnt}, 32'd2);
        tick();
        f_req = 1'b0; l_req = 1'b0;
        #1;
        chk("unlk_stall", {16'd0, stall_cnt}, 32'd4);
        chk("unlk_f_rdata", f_rdata, 32'hDEADBEEF);

        // reset with a response pending
        tick();
        f_req = 1'b1; f_addr = 32'h10;
        #1;
        chk("pend_gnt", {31'd0, f_gnt}, 32'd1);
        tick();
        rst = 1'b1; l_req = 1'b1;
        #1;
        chk("rst2_resp", {30'd0, f_rvalid, l_rvalid}, 32'd0);
        chk("rst2_gnt", {29'd0, f_gnt, l_gnt, mem_en}, 32'd0);
        chk("rst2_stall", {16'd0, stall_cnt}, 32'd0);
        chk("rst2_rdata", f_rdata, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rel_gnt", {30'd0, f_gnt, l_gnt}, 32'd2);
        chk("rel_resp", {30'd0, f_rvalid, l_rvalid}, 32'd0);
        tick(); #1;
        chk("rel2_gnt", {30'd0, f_gnt, l_gnt}, 32'd1);
        chk("rel2_f_rdata", f_rdata, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
